// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon-Hash256 controller slice.
package ascon_pkg;

  typedef logic [63:0] ascon_word_t;

  // Initial value of state word 0 for Ascon-Hash256.
  localparam ascon_word_t ASCON_HASH256_IV = 64'h0000_0801_00CC_0002;

  // Number of 64-bit words in the permutation state.
  localparam int ASCON_STATE_WORDS = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_W,
    ST_PERM_START,
    ST_PERM_WAIT,
    ST_ABSORB,
    ST_PAD,
    ST_SQUEEZE
  } ctrl_state_t;

  // Phase remembers what the running permutation belongs to, so PERM_WAIT
  // knows where to go once the core is ready again.
  typedef enum logic [2:0] {
    PH_INIT,
    PH_ABSORB,
    PH_PAD,
    PH_FINAL,
    PH_SQUEEZE
  } phase_t;

  // Byte counts above 8 are treated as a full block.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/ascon_hash_ctrl_if.sv
// Stream-side and core-side bundles for the Ascon-Hash256 controller.
interface ascon_hash_ctrl_if;
  import ascon_pkg::*;

  logic        msg_valid_i;
  logic        msg_ready_o;
  ascon_word_t msg_data_i;
  logic [3:0]  msg_bytes_i;
  logic        msg_last_i;

  logic        digest_valid_o;
  logic        digest_ready_i;
  ascon_word_t digest_data_o;
  logic        digest_last_o;

  // Environment side: produces message blocks, consumes digest words.
  modport master (
    output msg_valid_i, msg_data_i, msg_bytes_i, msg_last_i, digest_ready_i,
    input  msg_ready_o, digest_valid_o, digest_data_o, digest_last_o
  );

  // Controller side.
  modport slave (
    input  msg_valid_i, msg_data_i, msg_bytes_i, msg_last_i, digest_ready_i,
    output msg_ready_o, digest_valid_o, digest_data_o, digest_last_o
  );
endinterface

interface ascon_core_if;
  import ascon_pkg::*;

  logic        core_start_perm_o;
  logic        core_round_config_o;
  logic [2:0]  core_word_sel_o;
  ascon_word_t core_data_o;
  logic        core_write_en_o;
  logic        core_xor_en_o;
  ascon_word_t core_data_i;
  logic        core_ready_i;

  // Controller side: drives the core's register file and permutation start.
  modport master (
    output core_start_perm_o, core_round_config_o, core_word_sel_o,
           core_data_o, core_write_en_o, core_xor_en_o,
    input  core_data_i, core_ready_i
  );

  // Permutation core side.
  modport slave (
    input  core_start_perm_o, core_round_config_o, core_word_sel_o,
           core_data_o, core_write_en_o, core_xor_en_o,
    output core_data_i, core_ready_i
  );
endinterface

// File: rtl/ascon_pad64.sv
// Masks the unused bytes of a little-endian message block and inserts the
// 0x01 padding byte directly after the last valid byte.
module ascon_pad64
  import ascon_pkg::*;
(
  input  ascon_word_t data,
  input  logic [3:0]  num_bytes,
  output ascon_word_t padded
);

  logic [3:0] n;

  assign n = clamp_bytes(num_bytes);

  // Byte gi keeps message data below n, carries the pad bit at n, else zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_byte
    assign padded[8*gi +: 8] = (4'(gi) < n)  ? data[8*gi +: 8] :
                               (4'(gi) == n) ? 8'h01 : 8'h00;
  end

endmodule

// File: rtl/ascon_hash_ctrl.sv
// Sequencer that walks an external Ascon permutation core through one
// Ascon-Hash256 computation: state init, padded absorb, squeeze of the digest.
module ascon_hash_ctrl
  import ascon_pkg::*;
#(
  parameter ascon_word_t HASH_IV      = ASCON_HASH256_IV,
  parameter int          DIGEST_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  ascon_hash_ctrl_if.slave stream,
  ascon_core_if.master     core
);

  localparam int              CNT_W          = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGEST   = CNT_W'(DIGEST_WORDS - 1);
  localparam logic [2:0]      LAST_INIT_WORD = 3'(ASCON_STATE_WORDS - 1);

  ctrl_state_t      state_reg, state_next;
  phase_t           phase_reg, phase_next;
  logic [2:0]       word_cnt_reg, word_cnt_next;
  logic [CNT_W-1:0] dig_cnt_reg, dig_cnt_next;
  logic             armed_reg, armed_next;
  logic             done_reg, done_next;

  ascon_word_t      pad_word;
  logic             msg_full;

  ascon_pad64 u_pad (
    .data      (stream.msg_data_i),
    .num_bytes (stream.msg_bytes_i),
    .padded    (pad_word)
  );

  assign msg_full = (clamp_bytes(stream.msg_bytes_i) == 4'd8);

  assign busy_o                   = (state_reg != ST_IDLE);
  assign done_o                   = done_reg;
  assign core.core_round_config_o = 1'b1;

  // State register and counters; reset aborts any hash in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= PH_INIT;
      word_cnt_reg <= '0;
      dig_cnt_reg  <= '0;
      armed_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      word_cnt_reg <= word_cnt_next;
      dig_cnt_reg  <= dig_cnt_next;
      armed_reg    <= armed_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic and all core/stream outputs.
  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    word_cnt_next = word_cnt_reg;
    dig_cnt_next  = dig_cnt_reg;
    armed_next    = 1'b0;
    done_next     = 1'b0;

    core.core_start_perm_o = 1'b0;
    core.core_word_sel_o   = 3'd0;
    core.core_data_o       = '0;
    core.core_write_en_o   = 1'b0;
    core.core_xor_en_o     = 1'b0;

    stream.msg_ready_o    = 1'b0;
    stream.digest_valid_o = 1'b0;
    stream.digest_data_o  = '0;
    stream.digest_last_o  = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          state_next    = ST_INIT_W;
          word_cnt_next = '0;
          dig_cnt_next  = '0;
        end
      end

      // Every hash rewrites all five words, so an aborted run leaves no trace.
      ST_INIT_W: begin
        core.core_write_en_o = 1'b1;
        core.core_word_sel_o = word_cnt_reg;
        core.core_data_o     = (word_cnt_reg == 3'd0) ? HASH_IV : '0;
        if (word_cnt_reg == LAST_INIT_WORD) begin
          state_next = ST_PERM_START;
          phase_next = PH_INIT;
        end else begin
          word_cnt_next = word_cnt_reg + 3'd1;
        end
      end

      ST_PERM_START: begin
        core.core_start_perm_o = 1'b1;
        state_next             = ST_PERM_WAIT;
      end

      // The core's ready is still high from the previous run during the first
      // wait cycle, so it is only trusted once armed.
      ST_PERM_WAIT: begin
        armed_next = 1'b1;
        if (armed_reg && core.core_ready_i) begin
          unique case (phase_reg)
            PH_INIT, PH_ABSORB: state_next = ST_ABSORB;
            PH_PAD:             state_next = ST_PAD;
            default:            state_next = ST_SQUEEZE;
          endcase
        end
      end

      // A full final block needs its own permutation before the separate
      // padding block is absorbed; a short final block carries its pad bit.
      ST_ABSORB: begin
        stream.msg_ready_o   = 1'b1;
        core.core_word_sel_o = 3'd0;
        core.core_data_o     = pad_word;
        core.core_xor_en_o   = stream.msg_valid_i;
        if (stream.msg_valid_i) begin
          state_next = ST_PERM_START;
          if (!stream.msg_last_i) begin
            phase_next = PH_ABSORB;
          end else if (!msg_full) begin
            phase_next = PH_FINAL;
          end else begin
            phase_next = PH_PAD;
          end
        end
      end

      ST_PAD: begin
        core.core_word_sel_o = 3'd0;
        core.core_data_o     = 64'h1;
        core.core_xor_en_o   = 1'b1;
        state_next           = ST_PERM_START;
        phase_next           = PH_FINAL;
      end

      // Digest word is read straight from state word 0; it stays stable
      // because the core is idle until the word is accepted.
      ST_SQUEEZE: begin
        core.core_word_sel_o  = 3'd0;
        stream.digest_valid_o = 1'b1;
        stream.digest_data_o  = core.core_data_i;
        stream.digest_last_o  = (dig_cnt_reg == LAST_DIGEST);
        if (stream.digest_ready_i) begin
          if (dig_cnt_reg != LAST_DIGEST) begin
            dig_cnt_next = dig_cnt_reg + 1'b1;
            state_next   = ST_PERM_START;
            phase_next   = PH_SQUEEZE;
          end else begin
            dig_cnt_next = '0;
            done_next    = 1'b1;
            state_next   = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Directed and randomised bench for ascon_hash_ctrl, with a behavioural
// Ascon permutation core and an independent Ascon-Hash256 reference.
module tb_ascon_hash_ctrl;
  import ascon_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic busy_o;
  logic done_o;

  int checks = 0;
  int errors = 0;

  ascon_hash_ctrl_if s_if ();
  ascon_core_if      c_if ();

  ascon_hash_ctrl #(
    .HASH_IV      (ASCON_HASH256_IV),
    .DIGEST_WORDS (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .stream  (s_if.slave),
    .core    (c_if.master)
  );

  always #5 clk = ~clk;

  // ---------------- Ascon permutation (bench model) ----------------
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [4:0][63:0] ascon_perm(input logic [4:0][63:0] s_in);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s_in[0]; x1 = s_in[1]; x2 = s_in[2]; x3 = s_in[3]; x4 = s_in[4];
    for (int r = 0; r < 12; r++) begin
      x2 = x2 ^ {56'h0, 8'(((15 - r) << 4) | r)};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x4, x3, x2, x1, x0};
  endfunction

  // ---------------- Behavioural core ----------------
  logic [4:0][63:0] cst;
  logic             cready = 1'b1;
  int               ccnt = 0;
  int               perm_count = 0;
  int               pad_xor_count = 0;
  logic [63:0]      last_msg_xor = '0;
  bit               lat_rand = 1'b0;
  int               lat_fix = 2;

  assign c_if.core_data_i  = (c_if.core_word_sel_o <= 3'd4) ? cst[c_if.core_word_sel_o] : 64'h0;
  assign c_if.core_ready_i = cready;

  always @(posedge clk) begin
    if (rst) begin
      cready <= 1'b1;
      ccnt   <= 0;
    end else begin
      if (c_if.core_write_en_o && c_if.core_word_sel_o <= 3'd4) begin
        cst[c_if.core_word_sel_o] <= c_if.core_data_o;
      end else if (c_if.core_xor_en_o && c_if.core_word_sel_o <= 3'd4) begin
        cst[c_if.core_word_sel_o] <= cst[c_if.core_word_sel_o] ^ c_if.core_data_o;
        if (s_if.msg_ready_o) last_msg_xor <= c_if.core_data_o;
        else                  pad_xor_count <= pad_xor_count + 1;
      end
      if (c_if.core_start_perm_o) begin
        cready     <= 1'b0;
        ccnt       <= lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
        perm_count <= perm_count + 1;
      end else if (!cready) begin
        if (ccnt == 0) begin
          cst    <= ascon_perm(cst);
          cready <= 1'b1;
        end else begin
          ccnt <= ccnt - 1;
        end
      end
    end
  end

  // ---------------- Reference hash ----------------
  logic [7:0]  msg_buf [0:63];
  logic [63:0] exp_dig [4];
  int          exp_perms;

  task automatic ref_hash(input int len);
    logic [4:0][63:0] s;
    logic [63:0] blk;
    logic [7:0]  b;
    int npb;
    s = '0;
    s[0] = ASCON_HASH256_IV;
    s = ascon_perm(s);
    npb = len / 8 + 1;
    for (int i = 0; i < npb; i++) begin
      blk = '0;
      for (int k = 0; k < 8; k++) begin
        if (i * 8 + k < len)       b = msg_buf[i * 8 + k];
        else if (i * 8 + k == len) b = 8'h01;
        else                       b = 8'h00;
        blk[8*k +: 8] = b;
      end
      s[0] = s[0] ^ blk;
      s = ascon_perm(s);
    end
    for (int i = 0; i < 4; i++) begin
      exp_dig[i] = s[0];
      if (i < 3) s = ascon_perm(s);
    end
    exp_perms = npb + 4;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- One hash transaction ----------------
  // gaps: random valid/ready gaps; hold: keep start_i high; clamp: send 15
  // instead of 8 on a full final block; abort_perm: assert rst once that
  // many permutations of this run have been started.
  task automatic run_hash(input string name, input int len, input bit gaps,
                          input bit hold, input bit clamp, input int abort_perm);
    int nblk, blk, got_n, first_perm, base_perm, base_pad, done_cnt, nb;
    bit offer, finished, aborted, hold_pend;
    logic [63:0] hold_data;
    logic [63:0] got [4];
    nblk = (len == 0) ? 1 : (len + 7) / 8;
    ref_hash(len);
    base_perm = perm_count;
    base_pad  = pad_xor_count;
    blk = 0; got_n = 0; first_perm = -1; done_cnt = 0;
    offer = 0; finished = 0; aborted = 0; hold_pend = 0; hold_data = '0;
    for (int i = 0; i < 4; i++) got[i] = '0;

    @(negedge clk);
    start_i = 1'b1;
    for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      if (c_if.core_start_perm_o && first_perm < 0) first_perm = cyc;
      if (done_o) begin
        done_cnt++;
        finished = 1;
      end
      if (abort_perm > 0 && perm_count - base_perm == abort_perm) begin
        rst = 1'b1;
        aborted = 1;
        finished = 1;
      end
      if (!finished) begin
        if (!offer && blk < nblk && (!gaps || $urandom_range(0, 2) != 0)) begin
          nb = (blk == nblk - 1) ? len - 8 * blk : 8;
          for (int k = 0; k < 8; k++)
            s_if.msg_data_i[8*k +: 8] = (k < nb) ? msg_buf[blk * 8 + k]
                                                 : (gaps ? 8'($urandom) : 8'hFF);
          s_if.msg_bytes_i = (clamp && nb == 8 && blk == nblk - 1) ? 4'd15 : 4'(nb);
          s_if.msg_last_i  = (blk == nblk - 1);
          offer = 1;
        end
        s_if.msg_valid_i    = offer;
        s_if.digest_ready_i = !gaps || ($urandom_range(0, 1) == 1);
        #1;
        if (hold_pend) begin
          if (s_if.digest_valid_o) chk("digest_hold", s_if.digest_data_o, hold_data);
          hold_pend = 0;
        end
        if (offer && s_if.msg_ready_o) begin
          blk++;
          offer = 0;
        end
        if (s_if.digest_valid_o) begin
          if (s_if.digest_ready_i) begin
            chk("digest_last", 64'(s_if.digest_last_o), 64'(got_n == 3));
            if (got_n < 4) got[got_n] = s_if.digest_data_o;
            got_n++;
          end else begin
            hold_pend = 1;
            hold_data = s_if.digest_data_o;
          end
        end
      end
    end
    s_if.msg_valid_i    = 1'b0;
    s_if.digest_ready_i = 1'b0;
    if (aborted) begin
      $display("hash %s len=%0d aborted after %0d perms", name, len, perm_count - base_perm);
      return;
    end

    chk("finished", 64'(finished), 64'd1);
    chk("busy_at_done", 64'(busy_o), 64'd0);
    chk("init_latency", 64'(first_perm), 64'd6);
    chk("blocks_taken", 64'(blk), 64'(nblk));
    chk("digest_words", 64'(got_n), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("digest_h%0d", i), got[i], exp_dig[i]);
    chk("perm_count", 64'(perm_count - base_perm), 64'(exp_perms));
    chk("pad_count", 64'(pad_xor_count - base_pad), 64'((len > 0 && len % 8 == 0) ? 1 : 0));
    @(negedge clk);
    chk("done_pulse", 64'(done_o), 64'd0);
    chk("busy_after", 64'(busy_o), 64'(hold));
    $display("hash %s len=%0d perms=%0d h0=%h h3=%h", name, len,
             perm_count - base_perm, got[0], got[3]);
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    s_if.msg_valid_i    = 1'b0;
    s_if.msg_data_i     = '0;
    s_if.msg_bytes_i    = '0;
    s_if.msg_last_i     = 1'b0;
    s_if.digest_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_busy",        64'(busy_o), 64'd0);
    chk("rst_done",        64'(done_o), 64'd0);
    chk("rst_msg_ready",   64'(s_if.msg_ready_o), 64'd0);
    chk("rst_dig_valid",   64'(s_if.digest_valid_o), 64'd0);
    chk("rst_dig_last",    64'(s_if.digest_last_o), 64'd0);
    chk("rst_start_perm",  64'(c_if.core_start_perm_o), 64'd0);
    chk("rst_write_en",    64'(c_if.core_write_en_o), 64'd0);
    chk("rst_xor_en",      64'(c_if.core_xor_en_o), 64'd0);
    chk("rst_word_sel",    64'(c_if.core_word_sel_o), 64'd0);
    chk("rst_core_data",   c_if.core_data_o, 64'd0);
    chk("rst_round_cfg",   64'(c_if.core_round_config_o), 64'd1);
    rst = 1'b0;

    // Empty message: one block with n = 0 absorbs the lone pad bit.
    run_hash("empty", 0, 0, 0, 0, 0);
    chk("empty_xor", last_msg_xor, 64'h0000_0000_0000_0001);

    // Full single block goes through the separate padding step.
    for (int k = 0; k < 8; k++) msg_buf[k] = 8'(k);
    run_hash("bytes00_07", 8, 0, 0, 0, 0);
    chk("full_xor", last_msg_xor, 64'h0706_0504_0302_0100);

    // "abc" with junk above byte 2 must be masked.
    msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
    run_hash("abc", 3, 0, 0, 0, 0);
    chk("abc_xor", last_msg_xor, 64'h0000_0000_0163_6261);

    // Oversized byte count on a full final block behaves like 8.
    for (int k = 0; k < 16; k++) msg_buf[k] = 8'(8'hA0 + k);
    run_hash("clamp16", 16, 0, 0, 1, 0);
    chk("clamp_xor", last_msg_xor, 64'hAFAE_ADAC_ABAA_A9A8);

    // start_i held high: one hash, then a fresh one only from IDLE.
    run_hash("hold_start", 0, 0, 1, 0, 0);
    chk("hold_restart_write", 64'(c_if.core_write_en_o), 64'd1);
    start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset while the second block's permutation is pending, then recover.
    lat_fix = 4;
    for (int k = 0; k < 24; k++) msg_buf[k] = 8'(8'h30 + k);
    run_hash("abort", 24, 0, 0, 0, 3);
    @(negedge clk);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_msg_ready", 64'(s_if.msg_ready_o), 64'd0);
    rst = 1'b0;
    lat_fix = 2;
    run_hash("after_abort", 0, 0, 0, 0, 0);
    chk("after_abort_xor", last_msg_xor, 64'h0000_0000_0000_0001);

    // Random lengths, contents, core latency and handshake gaps.
    lat_rand = 1'b1;
    for (int m = 0; m < 200; m++) begin
      int len;
      len = int'($urandom_range(0, 64));
      for (int k = 0; k < 64; k++) msg_buf[k] = 8'($urandom_range(0, 255));
      run_hash($sformatf("rand%0d", m), len, 1, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
